// File: rtl/iodelay_eye_align_ctrl.sv
// ---------------------------------------------------------------------------
// iodelay_eye_align_ctrl
// Per-channel alignment engine for an ISERDES/IODELAY capture path.
// On start_align it resets the IODELAY tap, sweeps taps upward looking for
// the first run of stable taps at least MIN_EYE wide, steps back to the
// middle of that run, then bitslips the deserialiser until TRAIN_PATTERN
// is seen. Completion is reported as a one-cycle data_aligned or align_fail
// pulse. All outputs are registered.
// ---------------------------------------------------------------------------
module iodelay_eye_align_ctrl #(
  parameter int                DATA_W        = 8,
  parameter int                TAP_W         = 5,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = 8'h2C,
  parameter int                SAMPLES       = 16,
  parameter int                SETTLE_CYC    = 8,
  parameter int                BITSLIP_WAIT  = 4,
  parameter int                MIN_EYE       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_align,
  input  logic [DATA_W-1:0] data_in,
  output logic              idelay_rst,
  output logic              idelay_ce,
  output logic              idelay_inc,
  output logic              bitslip,
  output logic              busy,
  output logic              data_aligned,
  output logic              align_fail,
  output logic [TAP_W-1:0]  tap_value,
  output logic [TAP_W:0]    eye_width
);

  // One shared wait/sample counter; it must hold the largest of the three waits.
  localparam int CNT_MAX_A = (SAMPLES > SETTLE_CYC) ? SAMPLES : SETTLE_CYC;
  localparam int CNT_MAX   = (CNT_MAX_A > BITSLIP_WAIT) ? CNT_MAX_A : BITSLIP_WAIT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int SLIP_W    = $clog2(DATA_W + 1);
  localparam int EYE_W     = TAP_W + 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLES - 1);
  localparam logic [CNT_W-1:0]  SWAIT_LAST  = CNT_W'(BITSLIP_WAIT - 1);
  localparam logic [SLIP_W-1:0] SLIP_ZERO   = {SLIP_W{1'b0}};
  localparam logic [SLIP_W-1:0] SLIP_ONE    = {{(SLIP_W-1){1'b0}}, 1'b1};
  localparam logic [SLIP_W-1:0] SLIP_LAST   = SLIP_W'(DATA_W - 1);
  localparam logic [TAP_W-1:0]  TAP_ZERO    = {TAP_W{1'b0}};
  localparam logic [TAP_W-1:0]  TAP_ONE     = {{(TAP_W-1){1'b0}}, 1'b1};
  localparam logic [TAP_W-1:0]  MAX_TAP     = {TAP_W{1'b1}};
  localparam logic [EYE_W-1:0]  EYE_ZERO    = {EYE_W{1'b0}};
  localparam logic [EYE_W-1:0]  EYE_ONE     = {{(EYE_W-1){1'b0}}, 1'b1};
  localparam logic [EYE_W-1:0]  MIN_EYE_W   = EYE_W'(MIN_EYE);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    DLY_RST   = 4'd1,
    SETTLE    = 4'd2,
    SAMPLE    = 4'd3,
    STEP      = 4'd4,
    CENTER    = 4'd5,
    SLIP_CHK  = 4'd6,
    SLIP      = 4'd7,
    SLIP_WAIT = 4'd8,
    DONE      = 4'd9,
    FAIL      = 4'd10
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   ref_r;
  logic                mismatch_r;
  logic                win_open_r;
  logic [TAP_W-1:0]    win_start_r;
  logic [TAP_W-1:0]    win_end_r;
  logic [TAP_W-1:0]    target_r;
  logic                centered_r;
  logic [SLIP_W-1:0]   slip_cnt_r;

  logic                tap_good_s;
  logic                tap_max_s;
  logic [TAP_W-1:0]    cand_start_s;
  logic [TAP_W-1:0]    cand_end_s;
  logic [EYE_W-1:0]    cand_width_s;
  logic [EYE_W-1:0]    cand_sum_s;
  logic [TAP_W-1:0]    cand_target_s;
  logic                eye_ok_s;
  logic                accept_s;

  // Verdict for the tap being sampled and the window it would close or extend.
  always_comb begin
    tap_good_s = (!mismatch_r) && (data_in == ref_r);
    tap_max_s  = (tap_value == MAX_TAP);
    if (tap_good_s) begin
      // A good tap extends the open window, or opens a new one at this tap.
      cand_start_s = win_open_r ? win_start_r : tap_value;
      cand_end_s   = tap_value;
    end else begin
      // A bad tap closes whatever window is open.
      cand_start_s = win_start_r;
      cand_end_s   = win_end_r;
    end
    cand_width_s  = {1'b0, cand_end_s} - {1'b0, cand_start_s} + EYE_ONE;
    cand_sum_s    = {1'b0, cand_start_s} + {1'b0, cand_end_s};
    cand_target_s = TAP_W'(cand_sum_s >> 1);
    eye_ok_s      = (cand_width_s >= MIN_EYE_W);
    if (tap_good_s) begin
      // An eye still open at the last tap is only accepted at the end of the sweep.
      accept_s = tap_max_s && eye_ok_s;
    end else begin
      accept_s = win_open_r && eye_ok_s;
    end
  end

  // Alignment sequencer: tap sweep, centring, bitslip search, registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      ref_r        <= {DATA_W{1'b0}};
      mismatch_r   <= 1'b0;
      win_open_r   <= 1'b0;
      win_start_r  <= TAP_ZERO;
      win_end_r    <= TAP_ZERO;
      target_r     <= TAP_ZERO;
      centered_r   <= 1'b0;
      slip_cnt_r   <= SLIP_ZERO;
      idelay_rst   <= 1'b0;
      idelay_ce    <= 1'b0;
      idelay_inc   <= 1'b0;
      bitslip      <= 1'b0;
      busy         <= 1'b0;
      data_aligned <= 1'b0;
      align_fail   <= 1'b0;
      tap_value    <= TAP_ZERO;
      eye_width    <= EYE_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_align) begin
            idelay_rst <= 1'b1;
            busy       <= 1'b1;
            state_r    <= DLY_RST;
          end else begin
            state_r    <= IDLE;
          end
        end

        DLY_RST: begin
          // The IODELAY takes its tap reset at the end of this cycle.
          idelay_rst  <= 1'b0;
          tap_value   <= TAP_ZERO;
          eye_width   <= EYE_ZERO;
          win_open_r  <= 1'b0;
          win_start_r <= TAP_ZERO;
          win_end_r   <= TAP_ZERO;
          target_r    <= TAP_ZERO;
          centered_r  <= 1'b0;
          slip_cnt_r  <= SLIP_ZERO;
          cnt_r       <= CNT_ZERO;
          state_r     <= SETTLE;
        end

        SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            cnt_r   <= CNT_ZERO;
            state_r <= centered_r ? SLIP_CHK : SAMPLE;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end

        SAMPLE: begin
          if (cnt_r == CNT_ZERO) begin
            // First word of the burst is the reference for the rest.
            ref_r      <= data_in;
            mismatch_r <= 1'b0;
            cnt_r      <= cnt_r + CNT_ONE;
          end else if (cnt_r != SAMPLE_LAST) begin
            mismatch_r <= mismatch_r | (data_in != ref_r);
            cnt_r      <= cnt_r + CNT_ONE;
          end else begin
            cnt_r <= CNT_ZERO;
            if (accept_s) begin
              // Latch the eye; decrement starts right away if the tap is past centre.
              win_start_r <= cand_start_s;
              win_end_r   <= cand_end_s;
              target_r    <= cand_target_s;
              eye_width   <= cand_width_s;
              idelay_ce   <= (tap_value > cand_target_s);
              idelay_inc  <= 1'b0;
              state_r     <= CENTER;
            end else if (tap_max_s) begin
              align_fail <= 1'b1;
              busy       <= 1'b0;
              state_r    <= FAIL;
            end else begin
              if (tap_good_s) begin
                win_open_r  <= 1'b1;
                win_start_r <= cand_start_s;
                win_end_r   <= tap_value;
              end else begin
                // Too narrow (or no window at all): forget it and keep sweeping.
                win_open_r  <= 1'b0;
              end
              idelay_ce  <= 1'b1;
              idelay_inc <= 1'b1;
              state_r    <= STEP;
            end
          end
        end

        STEP: begin
          idelay_ce  <= 1'b0;
          idelay_inc <= 1'b0;
          tap_value  <= tap_value + TAP_ONE;
          cnt_r      <= CNT_ZERO;
          state_r    <= SETTLE;
        end

        CENTER: begin
          if (tap_value > target_r) begin
            // idelay_ce is high this cycle, so the IODELAY steps down with us.
            tap_value <= tap_value - TAP_ONE;
            idelay_ce <= ((tap_value - TAP_ONE) > target_r);
          end else begin
            idelay_ce  <= 1'b0;
            centered_r <= 1'b1;
            cnt_r      <= CNT_ZERO;
            state_r    <= SETTLE;
          end
        end

        SLIP_CHK: begin
          if (data_in == TRAIN_PATTERN) begin
            data_aligned <= 1'b1;
            busy         <= 1'b0;
            state_r      <= DONE;
          end else if (slip_cnt_r == SLIP_LAST) begin
            align_fail   <= 1'b1;
            busy         <= 1'b0;
            state_r      <= FAIL;
          end else begin
            bitslip      <= 1'b1;
            state_r      <= SLIP;
          end
        end

        SLIP: begin
          bitslip    <= 1'b0;
          slip_cnt_r <= slip_cnt_r + SLIP_ONE;
          cnt_r      <= CNT_ZERO;
          state_r    <= SLIP_WAIT;
        end

        SLIP_WAIT: begin
          if (cnt_r == SWAIT_LAST) begin
            cnt_r   <= CNT_ZERO;
            state_r <= SLIP_CHK;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end

        DONE: begin
          data_aligned <= 1'b0;
          state_r      <= IDLE;
        end

        FAIL: begin
          align_fail <= 1'b0;
          state_r    <= IDLE;
        end

        default: begin
          idelay_rst   <= 1'b0;
          idelay_ce    <= 1'b0;
          idelay_inc   <= 1'b0;
          bitslip      <= 1'b0;
          busy         <= 1'b0;
          data_aligned <= 1'b0;
          align_fail   <= 1'b0;
          cnt_r        <= CNT_ZERO;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule
